// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if
// Request/response bundle of the split-transaction SRAM-like port.
//   req, wr, size, wstrb, addr, wdata : request side, driven by the master
//   addr_ok                           : request accepted this cycle
//   data_ok, rdata                    : in-order response, one per accepted request
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder
// Word-addressed on-chip memory answering the SRAM-like split-transaction
// port. One request is accepted per cycle; each accepted request (read or
// write) produces exactly one in-order response LATENCY cycles later.
//   clk        : clock
//   reset      : synchronous active-high reset (clears the response queue only)
//   addr_stall : external backpressure, forces addr_ok low
//   bus        : slave side of the request/response bundle
module sram_like_responder #(
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  addr_stall,
    sram_like_responder_if.slave  bus
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [3:0]       DELAY_INIT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(OUTSTANDING - 1);

    logic [31:0]            mem [2**ADDR_W];

    logic [31:0]            q_data  [OUTSTANDING];
    logic [3:0]             q_delay [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_valid;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       cnt;

    logic [ADDR_W-1:0]      idx;
    logic                   accept;
    logic                   head_ready;
    logic                   unused_bits;

    // size, the byte offset and the address bits above the word index do not
    // select anything: addresses outside the array alias onto it.
    assign idx         = bus.addr[ADDR_W+1:2];
    assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A full queue refuses new requests even when the head pops this cycle,
    // which keeps addr_ok independent of the response path.
    always_comb begin
        accept     = bus.req & ~addr_stall & ~reset & (cnt < CNT_MAX);
        head_ready = q_valid[head] & (q_delay[head] == 4'd0);
    end

    assign bus.addr_ok = accept;
    assign bus.data_ok = head_ready;
    assign bus.rdata   = head_ready ? q_data[head] : 32'd0;

    // Memory array is never reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wstrb[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Response queue. Read data is captured at acceptance so later writes
    // cannot change a response already in flight. Every waiting entry ages
    // each cycle; a newly pushed entry starts at LATENCY-1 so that it becomes
    // ready LATENCY-1 edges after the acceptance edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            q_valid <= '0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (q_valid[i] && (q_delay[i] != 4'd0)) begin
                    q_delay[i] <= q_delay[i] - 4'd1;
                end
            end
            if (head_ready) begin
                q_valid[head] <= 1'b0;
                head          <= ptr_next(head);
            end
            if (accept) begin
                q_valid[tail] <= 1'b1;
                q_delay[tail] <= DELAY_INIT;
                q_data[tail]  <= bus.wr ? 32'd0 : mem[idx];
                tail          <= ptr_next(tail);
            end
            unique case ({accept, head_ready})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder
// Exercises two responder instances: dut (LATENCY 2) for directed and
// randomized traffic against a timestamp-based reference model, and dut_bp
// (LATENCY 8) for queue-full backpressure and reset while requests are in flight.
module tb_sram_like_responder;

    localparam int AW     = 10;
    localparam int LAT    = 2;
    localparam int OUT    = 4;
    localparam int LAT_BP = 8;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic reset_bp;
    logic stall_bp;

    always #5 clk = ~clk;

    sram_like_responder_if bus ();
    sram_like_responder_if bus_bp ();

    sram_like_responder #(.ADDR_W(AW), .LATENCY(LAT), .OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset), .addr_stall(stall), .bus(bus)
    );

    sram_like_responder #(.ADDR_W(AW), .LATENCY(LAT_BP), .OUTSTANDING(OUT)) dut_bp (
        .clk(clk), .reset(reset_bp), .addr_stall(stall_bp), .bus(bus_bp)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model for dut: each accepted request becomes a response due in
    // a known cycle number; the memory is a plain array of words.
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    resp_t       mq[$];
    logic [31:0] ref_mem [2**AW];
    int          cyc = 0;

    req_t        seq_q[$];
    logic [31:0] resp_q[$];

    function automatic logic m_addr_ok();
        return (bus.req === 1'b1) && (stall === 1'b0) && (reset === 1'b0) && (mq.size() < OUT);
    endfunction

    function automatic logic m_data_ok();
        return (mq.size() > 0) && (mq[0].due == cyc);
    endfunction

    function automatic logic [31:0] m_rdata();
        return m_data_ok() ? mq[0].data : 32'd0;
    endfunction

    function automatic req_t mk(input logic wr, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.wr = wr; r.strb = s; r.addr = a; r.data = d;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'd0;
    end

    // Model update at each edge: responses leave at their due cycle, accepted
    // requests are stamped with due = acceptance edge + LAT - 1.
    always @(posedge clk) begin
        logic  acc;
        resp_t r;
        int    idx;
        acc = m_addr_ok();
        if (reset === 1'b1) begin
            mq.delete();
        end else begin
            if (m_data_ok()) void'(mq.pop_front());
            if (acc) begin
                idx    = int'(bus.addr[AW+1:2]);
                r.due  = cyc + LAT;
                r.data = bus.wr ? 32'd0 : ref_mem[idx];
                mq.push_back(r);
                if (bus.wr) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.wstrb[k]) ref_mem[idx][8*k +: 8] = bus.wdata[8*k +: 8];
                    end
                end
            end
        end
        cyc++;
    end

    task automatic drive(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic st);
        bus.req = r; bus.wr = w; bus.size = 2'd2; bus.wstrb = s; bus.addr = a; bus.wdata = d;
        stall = st;
    endtask

    task automatic drive_bp(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] d);
        bus_bp.req = r; bus_bp.wr = w; bus_bp.size = 2'd2; bus_bp.wstrb = s; bus_bp.addr = a;
        bus_bp.wdata = d; stall_bp = 1'b0;
    endtask

    // Plays seq_q into dut one request per accepted cycle, collects responses.
    task automatic run_seq(input int cycles);
        resp_q.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (seq_q.size() > 0) drive(1'b1, seq_q[0].wr, seq_q[0].strb, seq_q[0].addr, seq_q[0].data, 1'b0);
            else                  drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
            #1;
            if (bus.data_ok === 1'b1) resp_q.push_back(bus.rdata);
            if (bus.req && bus.addr_ok === 1'b1) void'(seq_q.pop_front());
        end
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; reset_bp = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
        drive_bp(1'b1, 1'b0, 4'hF, 32'd0, 32'd0);
        #1;
        vectors++;
        if (bus.addr_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_gates_addr_ok got=%b exp=0", bus.addr_ok);
        end
        @(negedge clk);
        reset = 1'b0; reset_bp = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        drive_bp(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL post_reset_data_ok got=%b exp=0", bus.data_ok);
        end
        vectors++;
        if (bus.rdata !== 32'd0) begin
            miscompares++; $display("[TB] FAIL post_reset_rdata got=%h exp=00000000", bus.rdata);
        end
        vectors++;
        if (bus_bp.data_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL post_reset_bp_data_ok got=%b exp=0", bus_bp.data_ok);
        end
        vectors++;
        if (bus.addr_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL idle_addr_ok got=%b exp=0", bus.addr_ok);
        end
        bus.req = 1'b1;
        #1;
        vectors++;
        if (bus.addr_ok !== 1'b1) begin
            miscompares++; $display("[TB] FAIL addr_ok_follows_req got=%b exp=1", bus.addr_ok);
        end
        bus.req = 1'b0;
    endtask

    // Gives words 0..31 known contents so randomized reads are predictable.
    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom(), 1'b0);
            #1;
            vectors++;
            if (bus.addr_ok !== m_addr_ok() || bus.data_ok !== m_data_ok()) begin
                miscompares++;
                $display("[TB] FAIL fill_handshake got=%b%b exp=%b%b", bus.addr_ok, bus.data_ok, m_addr_ok(), m_data_ok());
            end
        end
        seq_q.delete();
        run_seq(6);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        #1;
        vectors++;
        if (bus.addr_ok !== 1'b1) begin
            miscompares++; $display("[TB] FAIL wr_accept got=%b exp=1", bus.addr_ok);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b0);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL wr_early_data_ok got=%b exp=0", bus.data_ok);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b1 || bus.rdata !== 32'd0) begin
            miscompares++; $display("[TB] FAIL wr_response got=%b/%h exp=1/00000000", bus.data_ok, bus.rdata);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
            miscompares++; $display("[TB] FAIL rd_response got=%b/%h exp=1/deadbeef", bus.data_ok, bus.rdata);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rd_single_pulse got=%b exp=0", bus.data_ok);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] got;
        seq_q.delete();
        seq_q.push_back(mk(1'b1, 4'hF, 32'h10, 32'h11223344));
        seq_q.push_back(mk(1'b1, 4'h5, 32'h10, 32'hAABBCCDD));
        seq_q.push_back(mk(1'b0, 4'h0, 32'h10, 32'd0));
        run_seq(10);
        vectors++;
        if (resp_q.size() != 3) begin
            miscompares++; $display("[TB] FAIL strobe_resp_count got=%0d exp=3", resp_q.size());
        end
        got = (resp_q.size() >= 3) ? resp_q[2] : 32'hxxxxxxxx;
        vectors++;
        if (got !== 32'h11BB33DD) begin
            miscompares++; $display("[TB] FAIL strobe_merge got=%h exp=11bb33dd", got);
        end
    endtask

    task automatic test_alias();
        logic [31:0] got;
        seq_q.delete();
        seq_q.push_back(mk(1'b1, 4'hF, 32'h1004, 32'h1234));
        seq_q.push_back(mk(1'b0, 4'h0, 32'h0004, 32'd0));
        run_seq(8);
        got = (resp_q.size() >= 2) ? resp_q[1] : 32'hxxxxxxxx;
        vectors++;
        if (got !== 32'h00001234) begin
            miscompares++; $display("[TB] FAIL alias_read got=%h exp=00001234", got);
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b1);
            #1;
            vectors++;
            if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0) begin
                miscompares++; $display("[TB] FAIL stall_hold got=%b%b exp=00", bus.addr_ok, bus.data_ok);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        vectors++;
        if (bus.addr_ok !== 1'b1) begin
            miscompares++; $display("[TB] FAIL stall_release got=%b exp=1", bus.addr_ok);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL stall_early_data_ok got=%b exp=0", bus.data_ok);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h11BB33DD) begin
            miscompares++; $display("[TB] FAIL stall_response got=%b/%h exp=1/11bb33dd", bus.data_ok, bus.rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a       = $urandom();
            a[11:2] = 10'($urandom_range(0, 31));
            reset   = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 4'($urandom()), a, $urandom(),
                  $urandom_range(0, 4) == 0);
            #1;
            vectors++;
            if (bus.addr_ok !== m_addr_ok()) begin
                miscompares++; $display("[TB] FAIL rand_addr_ok c=%0d got=%b exp=%b", c, bus.addr_ok, m_addr_ok());
            end
            vectors++;
            if (bus.data_ok !== m_data_ok() || bus.rdata !== m_rdata()) begin
                miscompares++;
                $display("[TB] FAIL rand_resp c=%0d got=%b/%h exp=%b/%h", c, bus.data_ok, bus.rdata, m_data_ok(), m_rdata());
            end
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        req_t        bp_seq[6];
        logic [31:0] bp_exp[6];
        logic        exp_ok;
        logic        exp_dv;
        int          k = 0;
        int          r = 0;
        bp_seq[0] = mk(1'b1, 4'hF, 32'h0, 32'hA0A0A0A0);
        bp_seq[1] = mk(1'b0, 4'h0, 32'h0, 32'd0);
        bp_seq[2] = mk(1'b1, 4'hF, 32'h4, 32'hB1B1B1B1);
        bp_seq[3] = mk(1'b0, 4'h0, 32'h4, 32'd0);
        bp_seq[4] = mk(1'b0, 4'h0, 32'h0, 32'd0);
        bp_seq[5] = mk(1'b0, 4'h0, 32'h4, 32'd0);
        bp_exp    = '{32'd0, 32'hA0A0A0A0, 32'd0, 32'hB1B1B1B1, 32'hA0A0A0A0, 32'hB1B1B1B1};
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (k < 6) drive_bp(1'b1, bp_seq[k].wr, bp_seq[k].strb, bp_seq[k].addr, bp_seq[k].data);
            else       drive_bp(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
            #1;
            exp_ok = (c <= 3) || (c == 9) || (c == 10);
            exp_dv = (c >= 8 && c <= 11) || (c == 17) || (c == 18);
            vectors++;
            if (bus_bp.addr_ok !== exp_ok) begin
                miscompares++; $display("[TB] FAIL bp_addr_ok c=%0d got=%b exp=%b", c, bus_bp.addr_ok, exp_ok);
            end
            vectors++;
            if (bus_bp.data_ok !== exp_dv) begin
                miscompares++; $display("[TB] FAIL bp_data_ok c=%0d got=%b exp=%b", c, bus_bp.data_ok, exp_dv);
            end
            if (exp_dv && r < 6) begin
                vectors++;
                if (bus_bp.rdata !== bp_exp[r]) begin
                    miscompares++; $display("[TB] FAIL bp_rdata n=%0d got=%h exp=%h", r, bus_bp.rdata, bp_exp[r]);
                end
                r++;
            end
            if (exp_ok) k++;
        end
    endtask

    task automatic test_reset_midflight();
        int n_ok  = 0;
        int n_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_bp(1'b1, 1'b0, 4'h0, 32'h0, 32'd0);
        end
        @(negedge clk);
        reset_bp = 1'b1;
        #1;
        vectors++;
        if (bus_bp.addr_ok !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midflight_reset_addr_ok got=%b exp=0", bus_bp.addr_ok);
        end
        @(negedge clk);
        reset_bp = 1'b0;
        drive_bp(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        for (int c = 0; c < 12; c++) begin
            #1;
            vectors++;
            if (bus_bp.data_ok !== 1'b0) begin
                miscompares++; $display("[TB] FAIL midflight_dropped c=%0d got=%b exp=0", c, bus_bp.data_ok);
            end
            @(negedge clk);
        end
        // An emptied queue must take four requests in a row again.
        for (int c = 0; c < 16; c++) begin
            if (c < 4) drive_bp(1'b1, 1'b0, 4'h0, 32'h4, 32'd0);
            else       drive_bp(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
            #1;
            if (c < 4) begin
                vectors++;
                if (bus_bp.addr_ok !== 1'b1) begin
                    miscompares++; $display("[TB] FAIL midflight_refill c=%0d got=%b exp=1", c, bus_bp.addr_ok);
                end
            end
            if (bus_bp.data_ok === 1'b1) begin
                n_rsp++;
                if (bus_bp.rdata === 32'hB1B1B1B1) n_ok++;
            end
            @(negedge clk);
        end
        vectors++;
        if (n_rsp != 4 || n_ok != 4) begin
            miscompares++; $display("[TB] FAIL midflight_memory got=%0d/%0d exp=4/4", n_ok, n_rsp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; reset_bp = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        drive_bp(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        test_reset();
        test_fill();
        test_write_read();
        test_partial_strobe();
        test_alias();
        test_stall();
        test_random();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
